// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side stream adapter: buffer occupancy encoding
// and the default data width used by the FIFO and its bench.
package fifo_rd_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e occ);
    case (occ)
      OCC_ONE: return 2'd1;
      OCC_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry head/tail buffer with occupancy FSM; head is always the oldest word.
// Flush empties the buffer without touching the stored data registers.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output occ_e             o_occ,
  output logic [WIDTH-1:0] o_head
);

  occ_e             r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_occ <= OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_head <= i_data;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Simultaneous push/pop replaces the head in place: no bubble.
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail <= i_data;
            r_occ  <= OCC_TWO;
          end else if (i_pop) begin
            r_occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
            else        r_occ  <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_head;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side to valid/ready stream adapter with credit-based read issue.
// Optional statistics (beat_count, err_underflow) enabled by FIFO_RD_STATS_EN.
module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF
`ifdef FIFO_RD_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
  , output logic [CNT_WIDTH-1:0] beat_count
  , output logic                 err_underflow
`endif
);

  logic                  r_inflight;
  occ_e                  w_occ;
  logic [FIFO_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic [2:0]            w_need;
  logic [2:0]            w_allow;

  assign m_valid = (w_occ != OCC_EMPTY);
  assign m_data  = w_head;
  assign w_pop   = m_valid & m_ready;
  assign w_push  = r_inflight & ~fifo_underflow & ~flush;

  // Credit: held + in-flight words, less the word leaving now, must fit in 2.
  assign w_need     = 3'(occ_count(w_occ)) + 3'(r_inflight);
  assign w_allow    = 3'd1 + 3'(w_pop);
  assign w_rd_en    = ~rst & ~flush & ~fifo_empty & (w_need <= w_allow);
  assign fifo_rd_en = w_rd_en;

  always_ff @(posedge clk) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= w_rd_en;
  end

  fifo_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (fifo_data_out),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] r_beat_count;
  logic                 r_err_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_count    <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_pop) r_beat_count <= r_beat_count + CNT_WIDTH'(1);
      if (r_inflight && fifo_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign beat_count    = r_beat_count;
  assign err_underflow = r_err_underflow;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Randomized bench for fifo_rd_stream_adapter against a queue-based reference
// model; stats ports are checked when FIFO_RD_STATS_EN is defined.
module tb_fifo_rd_stream_adapter;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, flush, fifo_empty, fifo_underflow, m_ready;
  logic [W-1:0] fifo_data_out;
  logic         fifo_rd_en, m_valid;
  logic [W-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]  beat_count;
  logic         err_underflow;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.FIFO_WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data)
`ifdef FIFO_RD_STATS_EN
    , .beat_count    (beat_count)
    , .err_underflow (err_underflow)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fq[$];   // contents of the upstream FIFO
  logic [W-1:0] mb[$];   // words the adapter should currently hold, oldest first
  bit           m_infl;
  logic [W-1:0] m_last_head;
  int unsigned  m_beats;
  bit           m_err;
  int           rd_seen, beat_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit i_rst, input bit i_flush, input bit i_ready, input bit i_uf);
    bit pop, rd;
    int credit;
    rst            = i_rst;
    flush          = i_flush;
    m_ready        = i_ready;
    fifo_underflow = i_uf & m_infl;
    fifo_empty     = (fq.size() == 0);
    #1;
    pop    = (mb.size() > 0) && i_ready;
    credit = mb.size() + int'(m_infl) - int'(pop);
    rd     = !i_rst && !i_flush && (fq.size() != 0) && (credit <= 1);
    check("m_valid", 32'(m_valid), 32'(mb.size() > 0));
    check("m_data", 32'(m_data), 32'(m_last_head));
    check("rd_en", 32'(fifo_rd_en), 32'(rd));
    check("buf_depth", 32'(mb.size() <= 2), 32'd1);
`ifdef FIFO_RD_STATS_EN
    check("beat_count", 32'(beat_count), m_beats & 32'hFFFF);
    check("err_underflow", 32'(err_underflow), 32'(m_err));
`endif
    if (fifo_rd_en) rd_seen++;
    if (m_valid && m_ready) beat_seen++;
    @(posedge clk);
    #1;
    if (i_rst) begin
      mb.delete();
      m_infl      = 1'b0;
      m_last_head = '0;
      m_beats     = 0;
      m_err       = 1'b0;
    end else begin
      if (pop) begin
        void'(mb.pop_front());
        m_beats++;
      end
      if (m_infl && fifo_underflow) m_err = 1'b1;
      if (m_infl && !fifo_underflow && !i_flush) mb.push_back(fifo_data_out);
      if (i_flush) mb.delete();
      else if (mb.size() > 0) m_last_head = mb[0];
      m_infl = rd;
    end
    if (rd) fifo_data_out = fq.pop_front();
  endtask

  task automatic reset_all();
    fq.delete();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    m_infl = 1'b0; m_last_head = '0; m_beats = 0; m_err = 1'b0;
    @(posedge clk);
    #1;

    // Reset while the FIFO holds two words, then release and stream them.
    fq = '{16'h1111, 16'h2222};
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("first_beat_data", 32'(m_data), 32'h1111);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Eight words at full rate.
    reset_all();
    for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
    rd_seen = 0; beat_seen = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_rate_reads", 32'(rd_seen), 32'd8);
    check("full_rate_beats", 32'(beat_seen), 32'd8);

    // Same preload with ready pattern 1,0,0,1.
    reset_all();
    for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
    beat_seen = 0;
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    check("toggle_beats", 32'(beat_seen), 32'd8);

    // Single word held under a 5-cycle stall.
    reset_all();
    fq.push_back(16'hABCD);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_word", 32'(m_data), 32'hABCD);
    rd_seen = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("no_extra_reads", 32'(rd_seen), 32'd0);

    // Flush with a full buffer, then with a word in flight.
    reset_all();
    for (int i = 0; i < 8; i++) fq.push_back(16'h5000 + W'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("flush_valid_low", 32'(m_valid), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Underflow on an in-flight return.
    reset_all();
    for (int i = 0; i < 6; i++) fq.push_back(16'h7000 + W'(i));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef FIFO_RD_STATS_EN
    check("err_sticky", 32'(err_underflow), 32'd1);
`endif

    // Randomized traffic with occasional reset, flush and underflow.
    for (int i = 0; i < 3000; i++) begin
      if (fq.size() < 3 && $urandom_range(0, 3) == 0)
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) fq.push_back(W'($urandom));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
